// File: rtl/rr_arb4_32.sv
// Round-robin 4:1 select stage feeding a fourmux32, with a one-entry output register.
// Latency: 1 cycle from accept (req_v & req_rdy) to y/y_v.
// Backpressure: while y is held (y_v & !y_rdy) no channel is accepted; full rate while y_rdy=1.

module fourmux32 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = d0;
    case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end
endmodule

module rr_arb4_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_v,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       req_rdy,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             y_v,
  input  logic             y_rdy,
  output logic [1:0]       y_src
);
  logic [1:0]       last;
  logic [1:0]       gidx;
  logic [1:0]       cand;
  logic             hit;
  logic             load;
  logic [WIDTH-1:0] y_mux;

  // Search starts just after the last winner; last itself is checked last so a lone requester is re-granted.
  always_comb begin
    hit  = 1'b0;
    gidx = last;
    cand = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!hit && req_v[cand]) begin
        hit  = 1'b1;
        gidx = cand;
      end
    end
  end

  assign load    = !y_v || y_rdy;
  assign s       = rst ? 2'd0 : gidx;
  assign req_rdy = (!rst && load && hit) ? (4'b0001 << gidx) : 4'b0000;

  fourmux32 #(.WIDTH(WIDTH)) u_mux (
    .s  (s),
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .y  (y_mux)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      y_v   <= 1'b0;
      y_src <= 2'd0;
      last  <= 2'd3;
    end else if (load) begin
      if (hit) begin
        y     <= y_mux;
        y_v   <= 1'b1;
        y_src <= gidx;
        last  <= gidx;
      end else begin
        y_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb4_32.sv
// Directed bench for rr_arb4_32: reset, single request, fairness, backpressure, skip/wrap, mid-run reset.
module tb_rr_arb4_32;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_v;
  logic [31:0] d0, d1, d2, d3;
  logic [3:0]  req_rdy;
  logic [1:0]  s;
  logic [31:0] y;
  logic        y_v;
  logic        y_rdy;
  logic [1:0]  y_src;

  int tests = 0;
  int fails = 0;

  rr_arb4_32 dut (
    .clk(clk), .rst(rst), .req_v(req_v),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .req_rdy(req_rdy), .s(s), .y(y), .y_v(y_v),
    .y_rdy(y_rdy), .y_src(y_src)
  );

  always #5 clk = ~clk;

  task automatic to_comb();
    @(negedge clk);
  endtask

  task automatic to_reg();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_v = 4'hF; y_rdy = 1'b1;
    d0 = 32'h0; d1 = 32'h1; d2 = 32'h2; d3 = 32'h3;
    for (int c = 0; c < 2; c++) begin
      to_comb();
      tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL reset_req_rdy c%0d got %b want 0000", c, req_rdy); end
      tests++; if (s !== 2'd0) begin fails++; $display("FAIL reset_s c%0d got %0d want 0", c, s); end
      to_reg();
      tests++; if (y_v !== 1'b0) begin fails++; $display("FAIL reset_y_v c%0d got %b want 0", c, y_v); end
      tests++; if (y !== 32'h0) begin fails++; $display("FAIL reset_y c%0d got %h want 0", c, y); end
      tests++; if (y_src !== 2'd0) begin fails++; $display("FAIL reset_y_src c%0d got %0d want 0", c, y_src); end
    end
    rst = 1'b0;
    to_comb();
    tests++; if (s !== 2'd0) begin fails++; $display("FAIL first_grant_s got %0d want 0", s); end
    tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL first_grant_req_rdy got %b want 0001", req_rdy); end
    to_reg();
    tests++; if (y_src !== 2'd0 || y_v !== 1'b1) begin fails++; $display("FAIL first_grant_load got src=%0d v=%b want src=0 v=1", y_src, y_v); end
  endtask

  task automatic test_single();
    req_v = 4'b0100; d2 = 32'hAAAA5555; y_rdy = 1'b1;
    to_comb();
    tests++; if (req_rdy !== 4'b0100) begin fails++; $display("FAIL single_req_rdy got %b want 0100", req_rdy); end
    tests++; if (s !== 2'd2) begin fails++; $display("FAIL single_s got %0d want 2", s); end
    to_reg();
    tests++; if (y !== 32'hAAAA5555) begin fails++; $display("FAIL single_y got %h want aaaa5555", y); end
    tests++; if (y_v !== 1'b1) begin fails++; $display("FAIL single_y_v got %b want 1", y_v); end
    tests++; if (y_src !== 2'd2) begin fails++; $display("FAIL single_y_src got %0d want 2", y_src); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    logic [1:0] exp_src;
    rst = 1'b1; req_v = 4'h0;
    to_reg();
    rst = 1'b0;
    req_v = 4'hF; y_rdy = 1'b1;
    d0 = 32'h0; d1 = 32'h1; d2 = 32'h2; d3 = 32'h3;
    for (int i = 0; i < 8; i++) begin
      exp_src = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_src;
      to_comb();
      tests++; if (req_rdy !== exp_rdy) begin fails++; $display("FAIL fair_req_rdy i%0d got %b want %b", i, req_rdy, exp_rdy); end
      to_reg();
      tests++; if (y_src !== exp_src) begin fails++; $display("FAIL fair_y_src i%0d got %0d want %0d", i, y_src, exp_src); end
      tests++; if (y !== 32'(i % 4)) begin fails++; $display("FAIL fair_y i%0d got %h want %h", i, y, 32'(i % 4)); end
      tests++; if (y_v !== 1'b1) begin fails++; $display("FAIL fair_y_v i%0d got %b want 1", i, y_v); end
    end
  endtask

  task automatic test_backpressure();
    d1 = 32'h1111_0001;
    req_v = 4'b0010; y_rdy = 1'b1;
    to_reg();
    tests++; if (y !== 32'h1111_0001 || y_src !== 2'd1) begin fails++; $display("FAIL bp_fill got y=%h src=%0d want y=11110001 src=1", y, y_src); end
    req_v = 4'hF; y_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_comb();
      tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL bp_req_rdy c%0d got %b want 0000", c, req_rdy); end
      to_reg();
      tests++; if (y !== 32'h1111_0001 || y_src !== 2'd1 || y_v !== 1'b1) begin fails++; $display("FAIL bp_hold c%0d got y=%h src=%0d v=%b want y=11110001 src=1 v=1", c, y, y_src, y_v); end
    end
    y_rdy = 1'b1;
    to_comb();
    tests++; if (req_rdy !== 4'b0100 || s !== 2'd2) begin fails++; $display("FAIL bp_release got rdy=%b s=%0d want rdy=0100 s=2", req_rdy, s); end
    to_reg();
    tests++; if (y_src !== 2'd2 || y !== 32'h2) begin fails++; $display("FAIL bp_release_load got src=%0d y=%h want src=2 y=2", y_src, y); end
  endtask

  task automatic test_skip_wrap();
    // last=2 on entry; the first grant of channel 3 moves it to 3.
    req_v = 4'b1000; y_rdy = 1'b1;
    to_reg();
    to_comb();
    tests++; if (req_rdy !== 4'b1000) begin fails++; $display("FAIL wrap_regrant got %b want 1000", req_rdy); end
    to_reg();
    tests++; if (y_v !== 1'b1 || y_src !== 2'd3) begin fails++; $display("FAIL wrap_no_bubble got v=%b src=%0d want v=1 src=3", y_v, y_src); end
    req_v = 4'b1001;
    to_comb();
    tests++; if (req_rdy !== 4'b0001 || s !== 2'd0) begin fails++; $display("FAIL wrap_to0 got rdy=%b s=%0d want rdy=0001 s=0", req_rdy, s); end
    to_reg();
    to_comb();
    tests++; if (req_rdy !== 4'b1000 || s !== 2'd3) begin fails++; $display("FAIL wrap_back3 got rdy=%b s=%0d want rdy=1000 s=3", req_rdy, s); end
    to_reg();
    req_v = 4'b0000;
    to_comb();
    tests++; if (req_rdy !== 4'b0000 || s !== 2'd3) begin fails++; $display("FAIL nohit_comb got rdy=%b s=%0d want rdy=0000 s=3", req_rdy, s); end
    to_reg();
    tests++; if (y_v !== 1'b0 || y !== 32'h3 || y_src !== 2'd3) begin fails++; $display("FAIL nohit_drain got v=%b y=%h src=%0d want v=0 y=3 src=3", y_v, y, y_src); end
  endtask

  task automatic test_mid_reset();
    d1 = 32'h0000_0011; d2 = 32'h0000_0022;
    req_v = 4'b0100; y_rdy = 1'b1;
    to_reg();
    tests++; if (y_v !== 1'b1 || y_src !== 2'd2) begin fails++; $display("FAIL mid_setup got v=%b src=%0d want v=1 src=2", y_v, y_src); end
    rst = 1'b1; req_v = 4'b0110;
    to_comb();
    tests++; if (req_rdy !== 4'b0000 || s !== 2'd0) begin fails++; $display("FAIL mid_rst_comb got rdy=%b s=%0d want rdy=0000 s=0", req_rdy, s); end
    to_reg();
    tests++; if (y_v !== 1'b0 || y !== 32'h0) begin fails++; $display("FAIL mid_rst_clear got v=%b y=%h want v=0 y=0", y_v, y); end
    rst = 1'b0;
    to_comb();
    tests++; if (req_rdy !== 4'b0010 || s !== 2'd1) begin fails++; $display("FAIL mid_first_grant got rdy=%b s=%0d want rdy=0010 s=1", req_rdy, s); end
    to_reg();
    tests++; if (y_src !== 2'd1 || y !== 32'h11) begin fails++; $display("FAIL mid_first_load got src=%0d y=%h want src=1 y=11", y_src, y); end
  endtask

  initial begin
    rst = 1'b1; req_v = 4'h0; y_rdy = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_skip_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
